// File: rtl/fft_spectrum_feeder.sv
// Spectrum feeder: captures FFT magnitude frames into a ping-pong buffer.
// It serves the front bank to the display one bin per data_req, with a read latency of 2.
// Optional peak hold: define FFT_PEAK_HOLD_EN.
module fft_spectrum_feeder #(
  parameter int unsigned POINTS = 256,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 12,
  parameter int unsigned SHIFT  = 4
) (
  input  logic              pix_clk,
  input  logic              sys_rst,
  input  logic              fft_valid,
  input  logic              fft_last,
  input  logic [15:0]       fft_mag,
  output logic              fft_ready,
  input  logic              data_req,
  input  logic              fft_point_done,
  output logic [DATA_W-1:0] fft_data,
  output logic [ADDR_W-1:0] fft_point_cnt,
  output logic              fft_data_valid,
  output logic              frame_drop
);

  typedef enum logic {StFill, StFull} wr_state_e;

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(POINTS - 1);
  localparam logic [15:0]       MaxVal  = 16'((32'd1 << DATA_W) - 1);

  wr_state_e         state_q, state_d;
  logic              front_q, front_d;
  logic              front_ok_q, front_ok_d;  // front bank holds a real frame
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic              wr_over_q, wr_over_d;    // more than POINTS samples in this frame
  logic              drop_q, drop_d;          // current input frame is being discarded
  logic              frame_drop_d;
  logic              wr_en, complete, swap;
  logic [15:0]       sc;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W:0]   wr_addr;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d, rd_bin;

  logic [DATA_W-1:0] mem [2*POINTS];
  logic [DATA_W-1:0] rd_raw_q, bin1, out_val;
  logic              v1_q, zero1_q;
  logic [ADDR_W-1:0] idx1_q;

  assign sc        = fft_mag >> SHIFT;
  assign wr_data   = (sc > MaxVal) ? {DATA_W{1'b1}} : sc[DATA_W-1:0];
  assign wr_addr   = {~front_q, wr_ptr_q};
  assign fft_ready = (state_q == StFill);
  assign bin1      = zero1_q ? '0 : rd_raw_q;

  // Write FSM, swap decision and read pointer next state
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    wr_over_d    = wr_over_q;
    drop_d       = drop_q;
    frame_drop_d = 1'b0;
    wr_en        = 1'b0;
    complete     = 1'b0;
    unique case (state_q)
      StFill: begin
        if (fft_valid) begin
          if (drop_q) begin
            if (fft_last) begin
              frame_drop_d = 1'b1;
              drop_d       = 1'b0;
            end
          end else begin
            wr_en    = ~wr_over_q;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (wr_ptr_q == LastIdx) wr_over_d = 1'b1;
            if (fft_last) begin
              wr_ptr_d  = '0;
              wr_over_d = 1'b0;
              if (wr_ptr_q == LastIdx && !wr_over_q) begin
                complete = 1'b1;
                state_d  = StFull;
              end else begin
                frame_drop_d = 1'b1;
              end
            end
          end
        end
      end
      StFull: begin
        // Frame arriving while the back bank is full is discarded whole
        if (fft_valid) begin
          if (fft_last) begin
            frame_drop_d = 1'b1;
            drop_d       = 1'b0;
          end else begin
            drop_d = 1'b1;
          end
        end
      end
    endcase
    swap = fft_point_done & ((state_q == StFull) | complete);
    if (swap) state_d = StFill;
    front_d    = swap ? ~front_q : front_q;
    front_ok_d = front_ok_q | swap;
    rd_bin     = fft_point_done ? '0 : rd_ptr_q;
    rd_ptr_d   = rd_bin + ADDR_W'(data_req);
  end

  // Control state registers
  always_ff @(posedge pix_clk) begin
    if (sys_rst) begin
      state_q    <= StFill;
      front_q    <= 1'b0;
      front_ok_q <= 1'b0;
      wr_ptr_q   <= '0;
      wr_over_q  <= 1'b0;
      drop_q     <= 1'b0;
      frame_drop <= 1'b0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      front_q    <= front_d;
      front_ok_q <= front_ok_d;
      wr_ptr_q   <= wr_ptr_d;
      wr_over_q  <= wr_over_d;
      drop_q     <= drop_d;
      frame_drop <= frame_drop_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Simple dual-port RAM; read targets the post-swap front bank
  always_ff @(posedge pix_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (data_req) rd_raw_q <= mem[{front_d, rd_bin}];
  end

`ifdef FFT_PEAK_HOLD_EN
  logic [DATA_W-1:0] peak_q [POINTS];
  logic [POINTS-1:0] ptag_q;
  logic              cur_tag_q;
  logic [DATA_W-1:0] peak_eff;

  // Stale tag means at least one swap since this bin was last served: decay by one
  always_comb begin
    peak_eff = peak_q[idx1_q];
    if (ptag_q[idx1_q] != cur_tag_q && peak_eff != '0) peak_eff = peak_eff - 1'b1;
    out_val = (bin1 > peak_eff) ? bin1 : peak_eff;
  end

  // Peak array and frame tag update
  always_ff @(posedge pix_clk) begin
    if (sys_rst) begin
      for (int i = 0; i < int'(POINTS); i++) peak_q[i] <= '0;
      ptag_q    <= '0;
      cur_tag_q <= 1'b0;
    end else begin
      if (swap) cur_tag_q <= ~cur_tag_q;
      if (v1_q) begin
        peak_q[idx1_q] <= out_val;
        ptag_q[idx1_q] <= cur_tag_q;
      end
    end
  end
`else
  assign out_val = bin1;
`endif

  // Read pipeline: stage 1 tracks the RAM read, stage 2 drives the outputs
  always_ff @(posedge pix_clk) begin
    if (sys_rst) begin
      v1_q           <= 1'b0;
      zero1_q        <= 1'b0;
      idx1_q         <= '0;
      fft_data       <= '0;
      fft_point_cnt  <= '0;
      fft_data_valid <= 1'b0;
    end else begin
      v1_q           <= data_req;
      if (data_req) begin
        idx1_q  <= rd_bin;
        zero1_q <= ~front_ok_d;
      end
      fft_data_valid <= v1_q;
      if (v1_q) begin
        fft_data      <= out_val;
        fft_point_cnt <= idx1_q;
      end
    end
  end

endmodule

// File: tb/tb_fft_spectrum_feeder.sv
module tb_fft_spectrum_feeder;
  localparam int P = 256;

  logic        pix_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        fft_valid = 1'b0, fft_last = 1'b0;
  logic [15:0] fft_mag = '0;
  logic        data_req = 1'b0, fft_point_done = 1'b0;
  logic        fft_ready, fft_data_valid, frame_drop;
  logic [11:0] fft_data;
  logic [7:0]  fft_point_cnt;

  fft_spectrum_feeder dut (
    .pix_clk(pix_clk), .sys_rst(sys_rst), .fft_valid(fft_valid), .fft_last(fft_last),
    .fft_mag(fft_mag), .fft_ready(fft_ready), .data_req(data_req),
    .fft_point_done(fft_point_done), .fft_data(fft_data), .fft_point_cnt(fft_point_cnt),
    .fft_data_valid(fft_data_valid), .frame_drop(frame_drop)
  );

  always #5 pix_clk = ~pix_clk;

  typedef struct packed {logic [11:0] d; logic [7:0] c;} exp_t;
  exp_t sb[$];
  int   checks = 0, failures = 0;

  // Reference model state
  int spec[P];
  int pend[P];
  bit m_full;
  int m_rd;
  int m_peak[P];
  bit m_ptag[P];
  bit m_tag;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int scale(input int m);
    int s = m / 16;
    return (s > 4095) ? 4095 : s;
  endfunction

  function automatic int mag_of(input int mode, input int k);
    case (mode)
      0: return k * 16;
      1: return 65535;
      2: return (255 - k) * 16 + 5;
      3: return (k == 5) ? 1600 : 0;
      default: return (k == 5) ? 160 : 0;
    endcase
  endfunction

  function automatic int serve(input int idx);
    int b;
`ifdef FFT_PEAK_HOLD_EN
    int pk;
`endif
    b = spec[idx];
`ifdef FFT_PEAK_HOLD_EN
    pk = m_peak[idx];
    if (m_ptag[idx] != m_tag && pk > 0) pk--;
    if (pk > b) b = pk;
    m_peak[idx] = b;
    m_ptag[idx] = m_tag;
`endif
    return b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < P; i++) begin
      spec[i] = 0; m_peak[i] = 0; m_ptag[i] = 0;
    end
    m_full = 0; m_rd = 0; m_tag = 0;
  endtask

  task automatic do_swap();
    spec = pend; m_full = 0; m_tag = ~m_tag;
  endtask

  task automatic tick();
    @(posedge pix_clk); #1;
  endtask

  task automatic push_req();
    exp_t e;
    e.d = 12'(serve(m_rd));
    e.c = 8'(m_rd);
    sb.push_back(e);
    m_rd = (m_rd + 1) % P;
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && sb.size() > 0; i++) tick();
    chk("scoreboard_drained", sb.size(), 0);
  endtask

  task automatic burst(input int n);
    data_req = 1'b1;
    for (int i = 0; i < n; i++) begin
      push_req();
      tick();
    end
    data_req = 1'b0;
    drain();
  endtask

  task automatic pdone();
    fft_point_done = 1'b1;
    if (m_full) do_swap();
    m_rd = 0;
    tick();
    fft_point_done = 1'b0;
  endtask

  // Streams one frame; combo raises fft_point_done and data_req with its fft_last
  task automatic frame(input int n, input int mode, input bit combo);
    int buffer[P];
    bit exp_drop;
    exp_drop = 0;
    chk("fft_ready_before_frame", fft_ready, !m_full);
    for (int k = 0; k < n; k++) begin
      fft_valid = 1'b1;
      fft_mag   = 16'(mag_of(mode, k));
      fft_last  = (k == n - 1);
      if (k < P) buffer[k] = scale(mag_of(mode, k));
      if (k == n - 1) begin
        if (!m_full && n == P) begin
          m_full = 1; pend = buffer;
        end else begin
          exp_drop = 1;
        end
        if (combo) begin
          data_req = 1'b1; fft_point_done = 1'b1;
          if (m_full) do_swap();
          m_rd = 0;
          push_req();
        end
      end
      tick();
    end
    fft_valid = 1'b0; fft_last = 1'b0; data_req = 1'b0; fft_point_done = 1'b0;
    chk("frame_drop", frame_drop, exp_drop);
    chk("fft_ready_after_frame", fft_ready, !m_full);
  endtask

  // Scoreboard checker for every output strobe
  always @(negedge pix_clk) begin
    exp_t e;
    if (!sys_rst && fft_data_valid === 1'b1) begin
      chk("strobe_has_expectation", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("fft_data", fft_data, e.d);
        chk("fft_point_cnt", fft_point_cnt, e.c);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    repeat (3) tick();
    sys_rst = 1'b0;
    chk("rst_fft_data", fft_data, 0);
    chk("rst_fft_point_cnt", fft_point_cnt, 0);
    chk("rst_fft_data_valid", fft_data_valid, 0);
    chk("rst_frame_drop", frame_drop, 0);
    chk("rst_fft_ready", fft_ready, 1);

    // Request before any frame: zero data, strobe two cycles later
    data_req = 1'b1;
    push_req();
    tick();
    data_req = 1'b0;
    chk("valid_latency_1", fft_data_valid, 0);
    tick();
    chk("valid_latency_2", fft_data_valid, 1);
    tick();
    chk("valid_single_cycle", fft_data_valid, 0);
    pdone();

    // Ramp frame, swap, full sweep plus wrap
    frame(P, 0, 0);
    pdone();
    chk("ready_after_swap", fft_ready, 1);
    burst(P + 1);

    // Saturation
    frame(P, 1, 0);
    pdone();
    burst(4);
    repeat (3) tick();
    chk("hold_fft_data", fft_data, 4095);
    chk("hold_fft_point_cnt", fft_point_cnt, 3);

    // Short frame dropped, display unchanged
    frame(200, 0, 0);
    burst(2);
    pdone();

    // Back bank full: third frame dropped, second served after swap
    frame(P, 2, 0);
    frame(P, 0, 0);
    pdone();
    chk("ready_after_second_swap", fft_ready, 1);
    burst(3);

    // Long frame dropped
    frame(300, 1, 0);

    // fft_last, fft_point_done and data_req together
    frame(P, 0, 1);
    drain();
    burst(1);

    // Peak hold sequence (plain values without the option)
    frame(P, 3, 0);
    pdone();
    burst(6);
    frame(P, 4, 0);
    pdone();
    burst(6);

    // Reset mid-frame with a read in flight
    for (int k = 0; k < 100; k++) begin
      fft_valid = 1'b1; fft_mag = 16'(k * 16);
      tick();
    end
    fft_valid = 1'b0;
    data_req = 1'b1;
    tick();
    data_req = 1'b0;
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    model_reset();
    chk("rst_cancel_valid_a", fft_data_valid, 0);
    tick();
    chk("rst_cancel_valid_b", fft_data_valid, 0);
    chk("rst_no_frame_drop", frame_drop, 0);
    burst(1);
    frame(P, 2, 0);
    pdone();
    burst(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
